// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO between the bus-side register write port and the UART
//   transmitter. Stores up to DEPTH bytes in a circular buffer and offers
//   them one at a time to uart_tx on a valid/ready pair. After each accept,
//   tx_data is held for one extra cycle (HOLD) because uart_tx samples its
//   data input on the edge after the handshake.
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   wr_en      push wr_data this cycle (dropped and ovf set when full)
//   wr_data    byte to enqueue
//   flush      discard all stored bytes and any byte being offered
//   ovf_clr    clear the sticky overflow flag
//   tx_valid   byte offered to uart_tx
//   tx_ready   uart_tx ready
//   tx_data    offered byte
//   level      bytes in storage (not counting the byte in tx_data)
//   full       level == DEPTH
//   empty      level == 0
//   lvl_low    level <= LOW_THRESH
//   ovf        sticky: a write was dropped
//   busy       storage not empty or output FSM not idle
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int LOW_THRESH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          ovf_clr,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [7:0]    tx_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          lvl_low,
    output logic          ovf,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          load;
    logic          push;
    logic          drop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign lvl_low  = (level <= (AW+1)'(LOW_THRESH));
    assign tx_valid = (state == OFFER);
    assign busy     = !empty || (state != IDLE);

    // full is the registered flag, so a write while full is dropped even
    // when a pop frees a slot on the same edge. flush swallows the write
    // without counting it as an overflow.
    assign push = wr_en && !full && !flush;
    assign drop = wr_en && full && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pop only happens as a load into tx_data, from IDLE or from HOLD.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        load       = 1'b1;
                        state_next = OFFER;
                    end
                end
                OFFER: begin
                    if (tx_ready) begin
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (!empty) begin
                        load       = 1'b1;
                        state_next = OFFER;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // tx_data survives a flush so an accept already in progress still
    // delivers the right byte to uart_tx.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            tx_data <= 8'h00;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({push, load})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A dropped write on the same edge as ovf_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule
